// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared WS2812B receiver constants and FSM encodings
//
// Purpose: FSM state encodings for the RX decoder and default cycle constants
//          for a 64 MHz system clock, reused by the decoder, the demux and the
//          benches.
// Ports:   none (package).
package ws2812b_pkg;

  // Decoder FSM state encodings.
  typedef logic [1:0] rx_state_t;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

  // Default cycle constants at 64 MHz.
  localparam int T_THRESH_64M = 38;    // 0.6 us 0/1 decision point
  localparam int MIN_HIGH_64M = 6;     // shortest legal high pulse
  localparam int MAX_HIGH_64M = 100;   // longest legal high pulse
  localparam int IDLE_64M     = 3200;  // 50 us reset/latch gap

  // Width of the high/low pulse counters: wide enough to hold the idle gap.
  function automatic int cnt_width(input int idle_cyc);
    return $clog2(idle_cyc + 1);
  endfunction

endpackage

// File: rtl/ws2812b_sync.sv
// rtl/ws2812b_sync.sv - 2-FF DIN synchroniser with edge strobes
//
// Purpose: brings the asynchronous DIN pin into the clk domain and keeps the
//          previous synchronised value to produce single-cycle edge strobes.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high reset
//   din       in  asynchronous data pin
//   din_sync  out din after two flops (2-clk latency)
//   rise      out 1 in the first cycle din_sync is 1
//   fall      out 1 in the first cycle din_sync is 0
module ws2812b_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign din_sync = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_rx_decoder.sv
// rtl/ws2812b_rx_decoder.sv - WS2812B pulse-width bit/byte decoder
//
// Purpose: measures every high pulse on the synchronised DIN line, classifies
//          it as a 0 or 1, assembles bits MSB-first into bytes and detects the
//          >= IDLE_CYC low reset/latch gap.
// Optional feature: define WS2812B_RX_ERRCHK_EN to flag runt (< MIN_HIGH_CYC)
//          and overlong (> MAX_HIGH_CYC) pulses on err and resynchronise on the
//          next idle gap. Without it err is held 0 and such pulses decode
//          normally.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high reset
//   din         in  asynchronous WS2812B data pin
//   din_sync    out synchronised din (forwarded to the demux)
//   bit_valid   out 1-cycle pulse per decoded bit
//   bit_value   out decoded bit, valid with bit_valid
//   byte_valid  out 1-cycle pulse with the 8th bit of a byte
//   byte_data   out assembled byte, held until the next byte_valid
//   idle        out level, line low for >= IDLE_CYC since the last pulse
//   err         out 1-cycle pulse on a malformed pulse
module ws2812b_rx_decoder
  import ws2812b_pkg::*;
#(
  parameter int T_THRESH_CYC = T_THRESH_64M,
  parameter int IDLE_CYC     = IDLE_64M
`ifdef WS2812B_RX_ERRCHK_EN
  ,
  parameter int MIN_HIGH_CYC = MIN_HIGH_64M,
  parameter int MAX_HIGH_CYC = MAX_HIGH_64M
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       din_sync,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       idle,
  output logic       err
);

  localparam int CW = cnt_width(IDLE_CYC);

  localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_CYC);
  localparam logic [CW-1:0] IDLE_M1  = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] THRESH   = CW'(T_THRESH_CYC);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic rise;
  logic fall;

  rx_state_t   state;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] low_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_q;   // the 8th bit completes the byte straight into byte_data
  logic          err_q;
  logic          new_bit;
  logic          runt;
  logic          overlong;

  ws2812b_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_sync (din_sync),
    .rise     (rise),
    .fall     (fall)
  );

  assign new_bit = (high_cnt >= THRESH);

`ifdef WS2812B_RX_ERRCHK_EN
  localparam logic [CW-1:0] MIN_LIM = CW'(MIN_HIGH_CYC);
  localparam logic [CW-1:0] MAX_LIM = CW'(MAX_HIGH_CYC);
  assign runt     = (high_cnt < MIN_LIM);
  // high_cnt == MAX while din_sync is still 1 means this cycle is high cycle MAX+1.
  assign overlong = (high_cnt == MAX_LIM);
`else
  assign runt     = 1'b0;
  assign overlong = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT_IDLE;
      high_cnt   <= '0;
      low_cnt    <= '0;
      bit_cnt    <= 3'd0;
      shift_q    <= 7'd0;
      bit_valid  <= 1'b0;
      bit_value  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      idle       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      err_q      <= 1'b0;

      case (state)
        // Pulses are ignored until a full low gap proves we are between frames.
        ST_WAIT_IDLE: begin
          if (din_sync) begin
            low_cnt <= '0;
          end else if (low_cnt >= IDLE_M1) begin
            low_cnt <= IDLE_LIM;
            idle    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (rise) begin
            idle     <= 1'b0;
            high_cnt <= CW'(1);
            bit_cnt  <= 3'd0;
            shift_q  <= 7'd0;
            state    <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            // The falling cycle is already the first low cycle of the gap.
            low_cnt <= CW'(1);
            if (runt) begin
              err_q <= 1'b1;
              state <= ST_WAIT_IDLE;
            end else begin
              bit_valid <= 1'b1;
              bit_value <= new_bit;
              shift_q   <= {shift_q[5:0], new_bit};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_valid <= 1'b1;
                byte_data  <= {shift_q, new_bit};
              end
              state <= ST_LOW;
            end
          end else if (overlong) begin
            err_q   <= 1'b1;
            low_cnt <= '0;
            state   <= ST_WAIT_IDLE;
          end else if (high_cnt != CNT_MAX) begin
            high_cnt <= high_cnt + 1'b1;
          end
        end

        ST_LOW: begin
          if (rise) begin
            high_cnt <= CW'(1);
            state    <= ST_HIGH;
          end else if (low_cnt >= IDLE_M1) begin
            // Latch gap: any partial byte is dropped and assembly realigns.
            low_cnt <= IDLE_LIM;
            idle    <= 1'b1;
            bit_cnt <= 3'd0;
            shift_q <= 7'd0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// tb/tb_ws2812b_rx_decoder.sv - scoreboard bench for ws2812b_rx_decoder
module tb_ws2812b_rx_decoder;

  localparam int T0H = 26;
  localparam int T0L = 54;
  localparam int T1H = 51;
  localparam int T1L = 29;
  localparam int GAP = 3840;   // 60 us at 64 MHz

`ifdef WS2812B_RX_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_sync;
  logic       bit_valid;
  logic       bit_value;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       idle;
  logic       err;

  always #5 clk = ~clk;

  ws2812b_rx_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_sync   (din_sync),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .idle       (idle),
    .err        (err)
  );

  typedef struct packed {
    logic       v;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic v, input logic last, input logic [7:0] data);
    exp_t e;
    e.v    = v;
    e.last = last;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int th, input int tl);
    din = 1'b1;
    repeat (th) @(negedge clk);
    din = 1'b0;
    repeat (tl) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input logic last, input logic [7:0] data,
                          input logic expect_out);
    if (expect_out) push_exp(v, last, data);
    if (v) pulse(T1H, T1L);
    else   pulse(T0H, T0L);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_out);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0), b, expect_out);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_din_sync"},   din_sync,   0);
    chk({tag, "_bit_valid"},  bit_valid,  0);
    chk({tag, "_bit_value"},  bit_value,  0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_byte_data"},  byte_data,  0);
    chk({tag, "_idle"},       idle,       0);
    chk({tag, "_err"},        err,        0);
  endtask

  // Monitor: every decoded bit is matched against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0) begin
      if (err) err_seen++;
      if (byte_valid && !bit_valid) chk("byte_without_bit", byte_valid, 0);
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", bit_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bit_value", bit_value, e.v);
          chk("byte_valid", byte_valid, e.last);
          if (e.last) chk("byte_data", byte_data, e.data);
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // 1. idle rises after exactly IDLE_CYC low cycles.
    repeat (3199) @(negedge clk);
    chk("t1_idle_early", idle, 0);
    @(negedge clk);
    chk("t1_idle_on", idle, 1);

    // 2. 0xA5; first bit watches idle drop on the first sampled din_sync=1.
    push_exp(1'b1, 1'b0, 8'hA5);
    din = 1'b1;
    @(negedge clk);
    chk("t2_sync_lag1", din_sync, 0);
    chk("t2_idle_hold1", idle, 1);
    @(negedge clk);
    chk("t2_sync_lag2", din_sync, 1);
    chk("t2_idle_hold2", idle, 1);
    @(negedge clk);
    chk("t2_idle_fall", idle, 0);
    repeat (T1H - 3) @(negedge clk);
    din = 1'b0;
    repeat (T1L) @(negedge clk);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'hA5;
      send_bit(b[i], (i == 0), 8'hA5, 1'b1);
    end
    gap(GAP);
    chk("t2_idle_after", idle, 1);
    chk("t2_byte_hold", byte_data, 8'hA5);

    // 3. Three bytes then a latch gap.
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    chk("t3_idle_busy", idle, 0);
    gap(GAP);
    chk("t3_idle_after", idle, 1);
    chk("t3_byte_hold", byte_data, 8'h56);

    // 4. Partial byte dropped at the gap, next byte realigned.
    send_bit(1'b1, 1'b0, 8'h00, 1'b1);
    send_bit(1'b0, 1'b0, 8'h00, 1'b1);
    send_bit(1'b1, 1'b0, 8'h00, 1'b1);
    send_bit(1'b1, 1'b0, 8'h00, 1'b1);
    send_bit(1'b0, 1'b0, 8'h00, 1'b1);
    gap(GAP);
    chk("t4_idle_mid", idle, 1);
    chk("t4_partial_dropped", byte_data, 8'h56);
    send_byte(8'hFF, 1'b1);
    gap(GAP);
    chk("t4_byte_ff", byte_data, 8'hFF);

    // 5. Threshold boundary: 37 -> 0, 38 -> 1.
    push_exp(1'b0, 1'b0, 8'h00);
    pulse(37, 40);
    push_exp(1'b1, 1'b0, 8'h00);
    pulse(38, 40);
    gap(GAP);
    chk("t5_idle_after", idle, 1);
    chk("t5_byte_hold", byte_data, 8'hFF);

    // 6. Runt and overlong pulses.
    if (!ERRCHK) push_exp(1'b0, 1'b0, 8'h00);
    pulse(3, 100);
    chk("t6_runt_idle", idle, 0);
    chk("t6_runt_err_count", err_seen, ERRCHK ? 1 : 0);
    gap(GAP);
    chk("t6_runt_gap_idle", idle, 1);
    if (!ERRCHK) push_exp(1'b1, 1'b0, 8'h00);
    din = 1'b1;
    repeat (102) @(negedge clk);
    chk("t6_long_err_early", err, 0);
    @(negedge clk);
    chk("t6_long_err_101", err, ERRCHK ? 1 : 0);
    repeat (150 - 103) @(negedge clk);
    din = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_long_err_count", err_seen, ERRCHK ? 2 : 0);
    gap(GAP);
    chk("t6_long_gap_idle", idle, 1);

    // 7. Reset mid-byte, then a byte that must be ignored until a fresh gap.
    send_bit(1'b0, 1'b0, 8'h00, 1'b1);
    send_bit(1'b0, 1'b0, 8'h00, 1'b1);
    send_bit(1'b1, 1'b0, 8'h00, 1'b1);
    din = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t7_reset");
    reset = 1'b0;
    repeat (41) @(negedge clk);
    din = 1'b0;
    repeat (40) @(negedge clk);
    send_byte(8'h3C, 1'b0);
    chk("t7_no_idle_yet", idle, 0);
    chk("t7_byte_cleared", byte_data, 8'h00);
    gap(GAP);
    chk("t7_idle_after", idle, 1);
    send_byte(8'hC3, 1'b1);
    gap(GAP);
    chk("t7_byte_c3", byte_data, 8'hC3);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_err_count", err_seen, ERRCHK ? 2 : 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
